fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 0, is the instruction address loaded into the PC on reset.
REQ-002 Width macros from define.v: `DATA_WIDTH is the instruction width; `ROM_ADDR_WIDTH is the ROM address width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 rom_addr  output  `ROM_ADDR_WIDTH  instruction ROM read address, equal to the current PC register.
REQ-006 instructor  input  `DATA_WIDTH  ROM read data, valid one cycle after rom_addr is presented.
REQ-007 jump_en  input  1  redirect request; sampled every cycle.
REQ-008 jump_addr  input  `ROM_ADDR_WIDTH  redirect target.
REQ-009 halt  input  1  level-sensitive; while high, no new fetches are issued.
REQ-010 ir_valid  output  1  instruction available to the decoder.
REQ-011 ir_ready  input  1  decoder accepts the instruction; handshake occurs when ir_valid and ir_ready are both high.
REQ-012 ir_data  output  `DATA_WIDTH  head-of-queue instruction.
REQ-013 ir_pc  output  `ROM_ADDR_WIDTH  address the head instruction was fetched from.

Function
REQ-014 Prefetch queue: 2-entry FIFO of {instruction, pc}; ir_valid/ir_data/ir_pc driven from the head entry, registered outputs.
REQ-015 Issue condition: not halt, not jump_en, (occupancy + inflight) < queue depth; inflight is 0 or 1.
REQ-016 On issue: inflight_q <= 1, issued address recorded, PC <= PC+1 modulo 2^`ROM_ADDR_WIDTH; 0x..FF wraps to 0.
REQ-017 Capture: when inflight_q=1 and no jump in the current cycle, instructor and the recorded address are written into the queue tail; latency rom_addr -> ir_valid = 2 cycles with empty queue.
REQ-018 Throughput: with ir_ready held high and no halt/jump, one handshake per cycle in steady state.
REQ-019 Simultaneous capture and handshake: both occur; occupancy unchanged.
REQ-020 Jump: PC <= jump_addr, queue flushed, in-flight return discarded, no issue that cycle; fetch at jump_addr issues the next cycle.
REQ-021 Jump with handshake in same cycle: handshake completes (decoder keeps head), then flush; ir_valid = 0 the next cycle.
REQ-022 Jump with halt in same cycle: PC <= jump_addr, flush applied, no issue until halt deasserts.
REQ-023 Halt: stops issue only; an in-flight return is still captured; queued entries remain available to the decoder.
REQ-024 State machine: BOOT (first cycle after reset, no capture) -> RUN; RUN -> HALTED when halt=1; HALTED -> RUN when halt=0; jump accepted in any state except BOOT.
REQ-025 Queue never overflows; write to a full queue never occurs by construction of REQ-015; asserted in simulation.
REQ-026 ir_data/ir_pc hold stable while ir_valid=1 and ir_ready=0.

Reset
REQ-027 While rst_n=0 at a clock edge: PC=RESET_PC, queue empty, inflight_q=0, state=BOOT, ir_valid=0, ir_data=0, ir_pc=0; rom_addr=RESET_PC.
REQ-028 Reset mid-operation discards queued and in-flight instructions; first fetch after release is from RESET_PC.

Configuration
REQ-029 Macro FETCH_PREFETCH_EN: defined -> queue depth 2 as above; undefined -> depth 1 (single instruction register), issue only when queue empty and nothing in flight, throughput at most one instruction per 2 cycles; all other requirements unchanged.

Verification
REQ-030 Reset release, RESET_PC=0, ir_ready=1 -> rom_addr 0,1,2,... on successive cycles; ir_pc 0 with ir_valid on cycle 2, then 1,2,3 each cycle.
REQ-031 ir_ready=0 for 5 cycles from start -> occupancy reaches 2, rom_addr stalls at 2, ir_pc holds 0; ir_ready=1 -> ir_pc 0,1,2 consecutive.
REQ-032 jump_en=1, jump_addr=0x40 while queue holds pcs 5,6 -> ir_valid=0 next cycle; next ir_pc=0x40 two cycles after rom_addr=0x40.
REQ-033 halt=1 for 4 cycles mid-stream -> rom_addr frozen, queued entries drained on ir_ready, ir_valid=0 once empty; resume continues at frozen address.
REQ-034 PC at max address (all ones) -> next rom_addr = 0, ir_pc sequence ...max, 0.
REQ-035 rst_n=0 for one cycle with 2 queued entries -> ir_valid=0 next cycle, refetch starts at RESET_PC; repeat REQ-030 with FETCH_PREFETCH_EN undefined -> ir_valid every other cycle.

Source files
------------

// File: rtl/fetch_unit_if.sv
// ============================================================================
// Module      : fetch_unit_if
// Description : Fetch unit bus bundle (ROM port, redirect/halt controls and
//               decoder handshake). Widths come from `DATA_WIDTH and
//               `ROM_ADDR_WIDTH (define.v); fallbacks are supplied here.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ROM_ADDR_WIDTH
`define ROM_ADDR_WIDTH 8
`endif

interface fetch_unit_if;
    logic [`ROM_ADDR_WIDTH-1:0] rom_addr;
    logic [`DATA_WIDTH-1:0]     instructor;
    logic                       jump_en;
    logic [`ROM_ADDR_WIDTH-1:0] jump_addr;
    logic                       halt;
    logic                       ir_valid;
    logic                       ir_ready;
    logic [`DATA_WIDTH-1:0]     ir_data;
    logic [`ROM_ADDR_WIDTH-1:0] ir_pc;

    // master: the fetch unit itself; slave: ROM, control and decoder side
    modport master (
        output rom_addr,
        input  instructor,
        input  jump_en,
        input  jump_addr,
        input  halt,
        output ir_valid,
        input  ir_ready,
        output ir_data,
        output ir_pc
    );

    modport slave (
        input  rom_addr,
        output instructor,
        output jump_en,
        output jump_addr,
        output halt,
        input  ir_valid,
        output ir_ready,
        input  ir_data,
        input  ir_pc
    );
endinterface

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch with prefetch queue, redirect and halt.
//               Macro FETCH_PREFETCH_EN selects a 2-entry queue (else 1 entry).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ROM_ADDR_WIDTH
`define ROM_ADDR_WIDTH 8
`endif

module fetch_unit #(
    parameter logic [`ROM_ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    fetch_unit_if.master bus
);

    localparam int c_aw = `ROM_ADDR_WIDTH;
    localparam int c_dw = `DATA_WIDTH;
`ifdef FETCH_PREFETCH_EN
    localparam int c_depth = 2;
`else
    localparam int c_depth = 1;
`endif
    localparam int c_cnt_w = $clog2(c_depth + 1);

    typedef enum logic [1:0] {
        S_BOOT   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [c_aw-1:0]        r_pc;
    logic                   r_inflight;
    logic [c_aw-1:0]        r_issued_pc;
    logic [c_cnt_w-1:0]     r_count;
    logic                   r_valid;
    logic [c_dw-1:0]        r_q_data [c_depth];
    logic [c_aw-1:0]        r_q_pc   [c_depth];

    logic                   w_jump;
    logic                   w_capture;
    logic                   w_pop;
    logic                   w_issue;
    logic [c_cnt_w:0]       w_occ_after;
    logic [c_cnt_w-1:0]     w_count_nxt;
    logic [c_cnt_w-1:0]     w_wr_idx;
    logic [c_dw-1:0]        w_q_data_nxt [c_depth];
    logic [c_aw-1:0]        w_q_pc_nxt   [c_depth];

    // ------------------------------------------------------------------
    // Control state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_jump      = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_BOOT: begin
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                w_jump    = bus.jump_en;
                w_capture = r_inflight && !bus.jump_en;
                if (bus.halt) begin
                    w_state_nxt = S_HALTED;
                end
            end
            S_HALTED: begin
                // Halt only gates issue; a pending ROM return still lands.
                w_jump    = bus.jump_en;
                w_capture = r_inflight && !bus.jump_en;
                if (!bus.halt) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_BOOT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Issue decision: occupancy counted after this cycle's dequeue so the
    // queue can stream one instruction per cycle without ever overflowing.
    // ------------------------------------------------------------------
    assign w_pop       = r_valid && bus.ir_ready;
    assign w_occ_after = ({1'b0, r_count} + {{c_cnt_w{1'b0}}, r_inflight})
                         - {{c_cnt_w{1'b0}}, w_pop};
    assign w_issue     = !bus.halt && !bus.jump_en
                         && (w_occ_after < (c_cnt_w + 1)'(c_depth));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc        <= RESET_PC;
            r_inflight  <= 1'b0;
            r_issued_pc <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_issued_pc <= r_pc;
            end
            if (w_jump) begin
                r_pc <= bus.jump_addr;
            end else if (w_issue) begin
                r_pc <= r_pc + c_aw'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Prefetch queue: shift-register FIFO, entry 0 is the head.
    // ------------------------------------------------------------------
    always_comb begin
        w_q_data_nxt = r_q_data;
        w_q_pc_nxt   = r_q_pc;
        w_count_nxt  = r_count;
        w_wr_idx     = r_count;
        if (w_jump) begin
            w_count_nxt = '0;
        end else begin
            if (w_pop) begin
                w_wr_idx = r_count - c_cnt_w'(1);
                for (int i = 0; i < c_depth - 1; i++) begin
                    w_q_data_nxt[i] = r_q_data[i + 1];
                    w_q_pc_nxt[i]   = r_q_pc[i + 1];
                end
            end
            if (w_capture) begin
                for (int i = 0; i < c_depth; i++) begin
                    if (c_cnt_w'(i) == w_wr_idx) begin
                        w_q_data_nxt[i] = bus.instructor;
                        w_q_pc_nxt[i]   = r_issued_pc;
                    end
                end
            end
            w_count_nxt = r_count + c_cnt_w'(w_capture) - c_cnt_w'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
            r_valid <= 1'b0;
            for (int i = 0; i < c_depth; i++) begin
                r_q_data[i] <= '0;
                r_q_pc[i]   <= '0;
            end
        end else begin
            r_count  <= w_count_nxt;
            r_valid  <= (w_count_nxt != '0);
            r_q_data <= w_q_data_nxt;
            r_q_pc   <= w_q_pc_nxt;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_capture && !w_pop && (r_count == c_cnt_w'(c_depth))));

    assign bus.rom_addr = r_pc;
    assign bus.ir_valid = r_valid;
    assign bus.ir_data  = r_q_data[0];
    assign bus.ir_pc    = r_q_pc[0];

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit; scoreboard of expected
//               fetch addresses plus cycle-accurate timing checks per scenario.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ROM_ADDR_WIDTH
`define ROM_ADDR_WIDTH 8
`endif

module tb_fetch_unit;

    localparam int AW = `ROM_ADDR_WIDTH;
    localparam int DW = `DATA_WIDTH;
`ifdef FETCH_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam logic [AW-1:0] MAXA = '1;

    logic            clk = 1'b0;
    logic            rst_n;
    int              vectors     = 0;
    int              miscompares = 0;
    logic            mon_en      = 1'b0;
    logic [AW-1:0]   sb_q [$];
    logic [AW-1:0]   mon_exp_pc;

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC('0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        return DW'(32'h9E37_79B9 * (32'(a) + 32'd1));
    endfunction

    // Synchronous ROM model: data for the presented address one cycle later
    always @(posedge clk) bus.instructor <= rom_word(bus.rom_addr);

    // Scoreboard: every handshake must match the next expected fetch address
    always @(negedge clk) begin
        if (mon_en && rst_n && bus.ir_valid && bus.ir_ready) begin
            if (sb_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL sb_unexpected: ir_pc=%0h but no entry expected", bus.ir_pc);
            end else begin
                mon_exp_pc = sb_q.pop_front();
                vectors++;
                if (bus.ir_pc !== mon_exp_pc) begin
                    miscompares++;
                    $display("FAIL sb_pc: got %0h, expected %0h", bus.ir_pc, mon_exp_pc);
                end
                vectors++;
                if (bus.ir_data !== rom_word(mon_exp_pc)) begin
                    miscompares++;
                    $display("FAIL sb_data: got %0h, expected %0h (pc %0h)",
                             bus.ir_data, rom_word(mon_exp_pc), mon_exp_pc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_expect_from(input logic [AW-1:0] first);
        sb_q.delete();
        for (int i = 0; i < 64; i++) sb_q.push_back(first + AW'(i));
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.ir_ready = 1'b1;
        repeat (3) tick();
        vectors++;
        if (bus.rom_addr !== '0) begin
            miscompares++;
            $display("FAIL reset_rom_addr: got %0h, expected 0", bus.rom_addr);
        end
        vectors++;
        if (bus.ir_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ir_valid: got %0b, expected 0", bus.ir_valid);
        end
        vectors++;
        if (bus.ir_data !== '0) begin
            miscompares++;
            $display("FAIL reset_ir_data: got %0h, expected 0", bus.ir_data);
        end
        vectors++;
        if (bus.ir_pc !== '0) begin
            miscompares++;
            $display("FAIL reset_ir_pc: got %0h, expected 0", bus.ir_pc);
        end
    endtask

    task automatic test_stream();
        logic [AW-1:0] exp_rom;
        logic [AW-1:0] exp_pc;
        logic          exp_valid;
        mon_en = 1'b1;
        sb_expect_from('0);
        bus.ir_ready = 1'b1;
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) tick();
            exp_rom   = AW'((DEPTH == 2) ? k : (k + 1) / 2);
            exp_valid = (k >= 2) && ((DEPTH == 2) || (k % 2 == 0));
            exp_pc    = AW'((DEPTH == 2) ? k - 2 : (k - 2) / 2);
            vectors++;
            if (bus.rom_addr !== exp_rom) begin
                miscompares++;
                $display("FAIL stream_rom_addr c%0d: got %0h, expected %0h", k, bus.rom_addr, exp_rom);
            end
            vectors++;
            if (bus.ir_valid !== exp_valid) begin
                miscompares++;
                $display("FAIL stream_ir_valid c%0d: got %0b, expected %0b", k, bus.ir_valid, exp_valid);
            end
            if (exp_valid) begin
                vectors++;
                if (bus.ir_pc !== exp_pc) begin
                    miscompares++;
                    $display("FAIL stream_ir_pc c%0d: got %0h, expected %0h", k, bus.ir_pc, exp_pc);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [AW-1:0] exp_pc;
        logic          exp_valid;
        rst_n = 1'b0;
        bus.ir_ready = 1'b0;
        tick();
        sb_expect_from('0);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) tick();
            if (k == 5) bus.ir_ready = 1'b1;
            if (k >= 2 && k <= 4) begin
                vectors++;
                if (bus.rom_addr !== AW'(DEPTH)) begin
                    miscompares++;
                    $display("FAIL bp_rom_stall c%0d: got %0h, expected %0h", k, bus.rom_addr, DEPTH);
                end
                vectors++;
                if (bus.ir_valid !== 1'b1 || bus.ir_pc !== '0) begin
                    miscompares++;
                    $display("FAIL bp_hold c%0d: got valid=%0b pc=%0h, expected valid=1 pc=0",
                             k, bus.ir_valid, bus.ir_pc);
                end
                vectors++;
                if (bus.ir_data !== rom_word('0)) begin
                    miscompares++;
                    $display("FAIL bp_data_stable c%0d: got %0h, expected %0h", k, bus.ir_data, rom_word('0));
                end
            end
            if (k >= 5) begin
                exp_valid = (DEPTH == 2) || ((k - 5) % 2 == 0);
                exp_pc    = AW'((DEPTH == 2) ? k - 5 : (k - 5) / 2);
                vectors++;
                if (bus.ir_valid !== exp_valid) begin
                    miscompares++;
                    $display("FAIL bp_drain_valid c%0d: got %0b, expected %0b", k, bus.ir_valid, exp_valid);
                end
                if (exp_valid) begin
                    vectors++;
                    if (bus.ir_pc !== exp_pc) begin
                        miscompares++;
                        $display("FAIL bp_drain_pc c%0d: got %0h, expected %0h", k, bus.ir_pc, exp_pc);
                    end
                end
            end
        end
    endtask

    task automatic test_jump();
        bus.ir_ready  = 1'b0;
        bus.jump_en   = 1'b1;
        bus.jump_addr = AW'(5);
        tick();
        sb_expect_from(AW'(5));
        bus.jump_en = 1'b0;
        repeat (3) tick();
        vectors++;
        if (bus.ir_valid !== 1'b1 || bus.ir_pc !== AW'(5)) begin
            miscompares++;
            $display("FAIL jump_fill: got valid=%0b pc=%0h, expected valid=1 pc=5", bus.ir_valid, bus.ir_pc);
        end
        vectors++;
        if (bus.rom_addr !== AW'(5 + DEPTH)) begin
            miscompares++;
            $display("FAIL jump_fill_rom: got %0h, expected %0h", bus.rom_addr, 5 + DEPTH);
        end
        // redirect in the same cycle as a handshake on the pc-5 entry
        bus.ir_ready  = 1'b1;
        bus.jump_en   = 1'b1;
        bus.jump_addr = AW'(8'h40);
        tick();
        sb_expect_from(AW'(8'h40));
        bus.jump_en = 1'b0;
        vectors++;
        if (bus.ir_valid !== 1'b0 || bus.rom_addr !== AW'(8'h40)) begin
            miscompares++;
            $display("FAIL jump_flush: got valid=%0b rom=%0h, expected valid=0 rom=40", bus.ir_valid, bus.rom_addr);
        end
        tick();
        vectors++;
        if (bus.ir_valid !== 1'b0 || bus.rom_addr !== AW'(8'h41)) begin
            miscompares++;
            $display("FAIL jump_c1: got valid=%0b rom=%0h, expected valid=0 rom=41", bus.ir_valid, bus.rom_addr);
        end
        tick();
        vectors++;
        if (bus.ir_valid !== 1'b1 || bus.ir_pc !== AW'(8'h40)) begin
            miscompares++;
            $display("FAIL jump_target: got valid=%0b pc=%0h, expected valid=1 pc=40", bus.ir_valid, bus.ir_pc);
        end
    endtask

    task automatic test_jump_halt();
        bus.halt      = 1'b1;
        bus.jump_en   = 1'b1;
        bus.jump_addr = AW'(8'h20);
        tick();
        sb_expect_from(AW'(8'h20));
        bus.jump_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (k > 0) tick();
            vectors++;
            if (bus.rom_addr !== AW'(8'h20) || bus.ir_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL jh_hold a%0d: got rom=%0h valid=%0b, expected rom=20 valid=0",
                         k, bus.rom_addr, bus.ir_valid);
            end
        end
        bus.halt = 1'b0;
        tick();
        vectors++;
        if (bus.rom_addr !== AW'(8'h21) || bus.ir_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL jh_resume: got rom=%0h valid=%0b, expected rom=21 valid=0", bus.rom_addr, bus.ir_valid);
        end
        tick();
        vectors++;
        if (bus.ir_valid !== 1'b1 || bus.ir_pc !== AW'(8'h20)) begin
            miscompares++;
            $display("FAIL jh_target: got valid=%0b pc=%0h, expected valid=1 pc=20", bus.ir_valid, bus.ir_pc);
        end
    endtask

    task automatic test_halt();
        logic [AW-1:0] frozen;
        frozen = AW'((DEPTH == 2) ? 6 : 3);
        rst_n = 1'b0;
        bus.ir_ready = 1'b1;
        tick();
        sb_expect_from('0);
        rst_n = 1'b1;
        for (int k = 0; k < 13; k++) begin
            if (k > 0) tick();
            if (k == 6)  bus.halt = 1'b1;
            if (k == 10) bus.halt = 1'b0;
            if (k >= 6 && k <= 10) begin
                vectors++;
                if (bus.rom_addr !== frozen) begin
                    miscompares++;
                    $display("FAIL halt_frozen c%0d: got %0h, expected %0h", k, bus.rom_addr, frozen);
                end
            end
            if (k == 8 || k == 9) begin
                vectors++;
                if (bus.ir_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL halt_drained c%0d: got %0b, expected 0", k, bus.ir_valid);
                end
            end
            if (k == 11) begin
                vectors++;
                if (bus.rom_addr !== frozen + AW'(1)) begin
                    miscompares++;
                    $display("FAIL halt_resume_rom: got %0h, expected %0h", bus.rom_addr, frozen + AW'(1));
                end
            end
            if (k == 12) begin
                vectors++;
                if (bus.ir_valid !== 1'b1 || bus.ir_pc !== frozen) begin
                    miscompares++;
                    $display("FAIL halt_resume_pc: got valid=%0b pc=%0h, expected valid=1 pc=%0h",
                             bus.ir_valid, bus.ir_pc, frozen);
                end
            end
        end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] exp_rom;
        bus.jump_en   = 1'b1;
        bus.jump_addr = MAXA - AW'(1);
        tick();
        sb_expect_from(MAXA - AW'(1));
        bus.jump_en = 1'b0;
        for (int k = 0; k < 9; k++) begin
            if (k > 0) tick();
            exp_rom = MAXA - AW'(1) + AW'((DEPTH == 2) ? k : (k + 1) / 2);
            vectors++;
            if (bus.rom_addr !== exp_rom) begin
                miscompares++;
                $display("FAIL wrap_rom c%0d: got %0h, expected %0h", k, bus.rom_addr, exp_rom);
            end
            if (k == 2) begin
                vectors++;
                if (bus.ir_valid !== 1'b1 || bus.ir_pc !== MAXA - AW'(1)) begin
                    miscompares++;
                    $display("FAIL wrap_first_pc: got valid=%0b pc=%0h, expected valid=1 pc=%0h",
                             bus.ir_valid, bus.ir_pc, MAXA - AW'(1));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bus.ir_ready = 1'b0;
        repeat (4) tick();
        vectors++;
        if (bus.ir_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL rmid_queued: got %0b, expected 1", bus.ir_valid);
        end
        rst_n = 1'b0;
        tick();
        vectors++;
        if (bus.ir_valid !== 1'b0 || bus.rom_addr !== '0 || bus.ir_pc !== '0) begin
            miscompares++;
            $display("FAIL rmid_cleared: got valid=%0b rom=%0h pc=%0h, expected 0 0 0",
                     bus.ir_valid, bus.rom_addr, bus.ir_pc);
        end
        sb_expect_from('0);
        bus.ir_ready = 1'b1;
        rst_n = 1'b1;
        tick();
        vectors++;
        if (bus.rom_addr !== AW'(1) || bus.ir_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rmid_refetch: got rom=%0h valid=%0b, expected rom=1 valid=0", bus.rom_addr, bus.ir_valid);
        end
        tick();
        vectors++;
        if (bus.ir_valid !== 1'b1 || bus.ir_pc !== '0) begin
            miscompares++;
            $display("FAIL rmid_first: got valid=%0b pc=%0h, expected valid=1 pc=0", bus.ir_valid, bus.ir_pc);
        end
        repeat (4) tick();
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.jump_en   = 1'b0;
        bus.jump_addr = '0;
        bus.halt      = 1'b0;
        bus.ir_ready  = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_jump();
        test_jump_halt();
        test_halt();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
